// File: rtl/coreid_pkg.sv
// ============================================================================
// Module      : coreid_pkg
// Description : Shared definitions for the core-ID reader and its responder:
//               default register address, maximum ID length, FSM state
//               encoding and a printable-character helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package coreid_pkg;

    // Register address at which the core-ID responder lives.
    localparam logic [7:0] COREID_REG_ADDR = 8'hFF;

    // Maximum number of ID bytes stored per run.
    localparam int COREID_MAXLEN = 16;

    // Reader FSM state encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_READ   = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } coreid_state_e;

    // True for printable ASCII (space through tilde).
    function automatic logic coreid_is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage : coreid_pkg

`default_nettype wire

// File: rtl/coreid_buf.sv
// ============================================================================
// Module      : coreid_buf
// Description : 16 x 8 byte store for the fetched core-ID string.
//               One synchronous write port, one combinational read port.
//               Contents are deliberately not reset.
// Ports       : clk       - clock
//               we_i      - write enable
//               waddr_i   - write address (4 bits)
//               wdata_i   - write data (8 bits)
//               raddr_i   - read address (4 bits)
//               rdata_o   - read data, combinational (8 bits)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coreid_buf (
    input  logic       clk,
    input  logic       we_i,
    input  logic [3:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [3:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [16];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : coreid_buf

`default_nettype wire

// File: rtl/coreid_reader.sv
// ============================================================================
// Module      : coreid_reader
// Description : Fetches a zero-terminated core-ID string from a register
//               responder, one byte per RD_HOLD+2 cycles, into a 16-byte
//               buffer readable combinationally through buf_idx/buf_data.
// Parameters  : REG_ADDR - responder register address
//               MAXLEN   - maximum bytes stored per run (1..16)
//               RD_HOLD  - cycles zxuno_regrd is held per byte (>= 2)
// Ports       : clk, rst (async, active high), start,
//               zxuno_addr, zxuno_regrd, regaddr_changed -> responder
//               din, oe_n                               <- responder
//               busy, done, len, trunc, err             -> status
//               buf_idx / buf_data                      -> buffer read port
// Options     : define COREID_READER_ASCII_CHECK_EN to reject non-printable
//               bytes (err=1, byte not stored, run ends).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coreid_reader
    import coreid_pkg::*;
#(
    parameter logic [7:0] REG_ADDR = COREID_REG_ADDR,
    parameter int         MAXLEN   = COREID_MAXLEN,
    parameter int         RD_HOLD  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] zxuno_addr,
    output logic       zxuno_regrd,
    output logic       regaddr_changed,
    input  logic [7:0] din,
    input  logic       oe_n,
    output logic       busy,
    output logic       done,
    output logic [4:0] len,
    output logic       trunc,
    output logic       err,
    input  logic [3:0] buf_idx,
    output logic [7:0] buf_data
);

    localparam logic [7:0] C_READ_LAST = 8'(RD_HOLD - 1);
    localparam logic [4:0] C_MAXLEN    = 5'(MAXLEN);

    coreid_state_e state_q;
    logic [7:0]    cnt_q;
    logic          fin_q;       // run ends after the current GAP
    logic          busy_q;
    logic          done_q;
    logic [4:0]    len_q;
    logic          trunc_q;
    logic          err_q;
    logic          regrd_q;
    logic          regaddr_changed_q;
    logic [7:0]    addr_q;

    logic          w_capture;
    logic          w_bad;
    logic          w_store;
    logic [4:0]    len_d;

    // Capture happens on the clock edge that closes the last READ cycle.
    assign w_capture = (state_q == ST_READ) && (cnt_q == C_READ_LAST);

`ifdef COREID_READER_ASCII_CHECK_EN
    assign w_bad = !coreid_is_printable(din);
`else
    assign w_bad = 1'b0;
`endif

    assign w_store = w_capture && !oe_n && (din != 8'h00) && !w_bad;
    assign len_d   = len_q + 5'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            cnt_q             <= 8'd0;
            fin_q             <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            len_q             <= 5'd0;
            trunc_q           <= 1'b0;
            err_q             <= 1'b0;
            regrd_q           <= 1'b0;
            regaddr_changed_q <= 1'b0;
            addr_q            <= 8'h00;
        end else begin
            done_q            <= 1'b0;
            regaddr_changed_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q           <= ST_SELECT;
                        busy_q            <= 1'b1;
                        addr_q            <= REG_ADDR;
                        regaddr_changed_q <= 1'b1;
                        len_q             <= 5'd0;
                        trunc_q           <= 1'b0;
                        err_q             <= 1'b0;
                        fin_q             <= 1'b0;
                    end
                end
                ST_SELECT: begin
                    state_q <= ST_READ;
                    regrd_q <= 1'b1;
                    cnt_q   <= 8'd0;
                end
                ST_READ: begin
                    if (w_capture) begin
                        state_q <= ST_GAP;
                        regrd_q <= 1'b0;
                        cnt_q   <= 8'd0;
                        if (oe_n || ((din != 8'h00) && w_bad)) begin
                            err_q <= 1'b1;
                            fin_q <= 1'b1;
                        end else if (din == 8'h00) begin
                            fin_q <= 1'b1;
                        end else begin
                            len_q <= len_d;
                            if (len_d == C_MAXLEN) begin
                                trunc_q <= 1'b1;
                                fin_q   <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_GAP: begin
                    // Two idle cycles let the responder advance and re-register.
                    if (cnt_q == 8'd1) begin
                        cnt_q <= 8'd0;
                        if (fin_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_READ;
                            regrd_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    addr_q  <= 8'h00;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    regrd_q <= 1'b0;
                    addr_q  <= 8'h00;
                end
            endcase
        end
    end

    coreid_buf u_buf (
        .clk     (clk),
        .we_i    (w_store),
        .waddr_i (len_q[3:0]),
        .wdata_i (din),
        .raddr_i (buf_idx),
        .rdata_o (buf_data)
    );

    assign zxuno_addr      = addr_q;
    assign zxuno_regrd     = regrd_q;
    assign regaddr_changed = regaddr_changed_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign len             = len_q;
    assign trunc           = trunc_q;
    assign err             = err_q;

endmodule : coreid_reader

`default_nettype wire

// File: tb/tb_coreid_reader.sv
// ============================================================================
// Module      : tb_coreid_reader
// Description : Directed self-checking bench for coreid_reader with a small
//               behavioural core-ID responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_coreid_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] zxuno_addr;
    logic       zxuno_regrd;
    logic       regaddr_changed;
    logic [7:0] din;
    logic       oe_n;
    logic       busy;
    logic       done;
    logic [4:0] len;
    logic       trunc;
    logic       err;
    logic [3:0] buf_idx = 4'd0;
    logic [7:0] buf_data;

    int total = 0;
    int bad   = 0;
    int cyc;
    int pulses;

    // Responder model
    logic [7:0] rom [32];
    logic       oe_force = 1'b0;
    int         idx = 0;
    logic       regrd_prev = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        regrd_prev <= zxuno_regrd;
        if (regaddr_changed)
            idx <= 0;
        else if (regrd_prev && !zxuno_regrd)
            idx <= idx + 1;
    end

    assign din  = rom[idx[4:0]];
    assign oe_n = oe_force;

    coreid_reader dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .zxuno_addr      (zxuno_addr),
        .zxuno_regrd     (zxuno_regrd),
        .regaddr_changed (regaddr_changed),
        .din             (din),
        .oe_n            (oe_n),
        .busy            (busy),
        .done            (done),
        .len             (len),
        .trunc           (trunc),
        .err             (err),
        .buf_idx         (buf_idx),
        .buf_data        (buf_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_id();
        logic [7:0] s [12];
        s = '{8'h54, 8'h32, 8'h34, 8'h2D, 8'h31, 8'h31,
              8'h30, 8'h32, 8'h32, 8'h30, 8'h31, 8'h37};
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        for (int i = 0; i < 12; i++) rom[i] = s[i];
    endtask

    // Sample start on the next edge (edge 0); returns just after it (cycle 1).
    task automatic kick();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count cycles until done; cycle 1 is the SELECT cycle.
    task automatic wait_done(input string tag, output int c);
        c = 1;
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            @(posedge clk); #1;
            c++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s: done never seen, observed=0 expected=1", tag);
        end
    endtask

    task automatic read_buf(input logic [3:0] i, input string tag, input logic [7:0] exp);
        buf_idx = i; #1;
        check(tag, {24'd0, buf_data}, {24'd0, exp});
    endtask

    initial begin
        load_id();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_addr", {24'd0, zxuno_addr}, 0);
        check("rst_flags", {25'd0, done, zxuno_regrd, regaddr_changed, trunc, err, 2'b00}, 0);
        check("rst_len", {27'd0, len}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", {31'd0, busy}, 0);

        // Normal fetch of "T24-11022017"
        kick();
        check("sel_rac", {31'd0, regaddr_changed}, 1);
        check("sel_addr", {24'd0, zxuno_addr}, 32'hFF);
        check("sel_busy", {31'd0, busy}, 1);
        @(posedge clk); #1;                      // cycle 2
        check("rd_c2", {31'd0, zxuno_regrd}, 1);
        check("rac_c2", {31'd0, regaddr_changed}, 0);
        repeat (2) @(posedge clk); #1;           // cycle 4
        check("rd_c4", {31'd0, zxuno_regrd}, 1);
        @(posedge clk); #1;                      // cycle 5
        check("gap_c5", {31'd0, zxuno_regrd}, 0);
        @(posedge clk); #1;                      // cycle 6
        check("gap_c6", {31'd0, zxuno_regrd}, 0);
        @(posedge clk); #1;                      // cycle 7
        check("rd_c7", {31'd0, zxuno_regrd}, 1);
        wait_done("id_done", cyc);
        cyc += 6;
        check("id_done_cyc", cyc, 67);
        check("id_len", {27'd0, len}, 12);
        check("id_trunc", {31'd0, trunc}, 0);
        check("id_err", {31'd0, err}, 0);
        check("id_busy_done", {31'd0, busy}, 1);
        read_buf(4'd0, "id_buf0", 8'h54);
        read_buf(4'd11, "id_buf11", 8'h37);
        @(posedge clk); #1;
        check("id_idle_busy", {31'd0, busy}, 0);
        check("id_idle_addr", {24'd0, zxuno_addr}, 0);
        check("id_done_pulse", {31'd0, done}, 0);
        check("id_len_hold", {27'd0, len}, 12);

        // Truncation: 16 bytes 0x41..0x50, no terminator
        for (int i = 0; i < 32; i++) rom[i] = 8'h41 + 8'(i);
        kick();
        wait_done("tr_done", cyc);
        check("tr_done_cyc", cyc, 82);
        check("tr_len", {27'd0, len}, 16);
        check("tr_trunc", {31'd0, trunc}, 1);
        check("tr_err", {31'd0, err}, 0);
        read_buf(4'd15, "tr_buf15", 8'h50);
        read_buf(4'd0, "tr_buf0", 8'h41);
        @(posedge clk); #1;

        // Responder absent
        load_id();
        oe_force = 1'b1;
        kick();
        check("oe_sel_len", {27'd0, len}, 0);
        check("oe_sel_trunc", {31'd0, trunc}, 0);
        wait_done("oe_done", cyc);
        check("oe_done_cyc", cyc, 7);
        check("oe_err", {31'd0, err}, 1);
        check("oe_len", {27'd0, len}, 0);
        oe_force = 1'b0;
        @(posedge clk); #1;

        // Reset mid-run at cycle 20
        kick();
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mr_busy", {31'd0, busy}, 0);
        check("mr_addr", {24'd0, zxuno_addr}, 0);
        check("mr_regrd", {31'd0, zxuno_regrd}, 0);
        check("mr_len", {27'd0, len}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("mr_busy2", {31'd0, busy}, 0);
        check("mr_flags", {29'd0, done, trunc, err}, 0);
        @(posedge clk); #1;
        kick();
        wait_done("mr_done", cyc);
        check("mr_relen", {27'd0, len}, 12);
        check("mr_reerr", {31'd0, err}, 0);
        @(posedge clk); #1;

        // Start held throughout: exactly one run, then re-arm from IDLE
        start = 1'b1;
        @(posedge clk); #1;                      // cycle 1
        pulses = 0;
        cyc = 1;
        for (int i = 0; i < 300; i++) begin
            if (regaddr_changed) pulses++;
            if (done) break;
            @(posedge clk); #1;
            cyc++;
        end
        check("hold_done_cyc", cyc, 67);
        check("hold_pulses", pulses, 1);
        @(posedge clk); #1;                      // cycle 68: IDLE
        check("hold_idle", {31'd0, busy}, 0);
        check("hold_idle_rac", {31'd0, regaddr_changed}, 0);
        @(posedge clk); #1;                      // cycle 69: second SELECT
        start = 1'b0;
        check("hold_rerun", {31'd0, regaddr_changed}, 1);
        wait_done("hold2_done", cyc);
        @(posedge clk); #1;

        // Non-printable byte at position 2
        load_id();
        rom[2] = 8'h07;
        kick();
        wait_done("np_done", cyc);
`ifdef COREID_READER_ASCII_CHECK_EN
        check("np_err", {31'd0, err}, 1);
        check("np_len", {27'd0, len}, 2);
`else
        check("np_err", {31'd0, err}, 0);
        check("np_len", {27'd0, len}, 12);
        read_buf(4'd2, "np_buf2", 8'h07);
`endif
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_coreid_reader

`default_nettype wire

// File: doc/coreid_reader.md
COREID_READER -- requirements
Module: coreid_reader

Interface
REQ-001 SHALL have parameter REG_ADDR, default 8'hFF, register address of the core-ID responder.
REQ-002 SHALL have parameter MAXLEN, default 16, maximum bytes fetched per run (1..16).
REQ-003 SHALL have parameter RD_HOLD, default 3, cycles zxuno_regrd is held high per byte (minimum 2).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request a fetch; sampled only in IDLE.
REQ-007 SHALL have port zxuno_addr  output  8  register address driven to responder.
REQ-008 SHALL have port zxuno_regrd  output  1  register read strobe.
REQ-009 SHALL have port regaddr_changed  output  1  one-cycle address-select pulse.
REQ-010 SHALL have port din  input  8  responder data byte.
REQ-011 SHALL have port oe_n  input  1  responder output enable, active-low.
REQ-012 SHALL have outputs busy(1), done(1, one-cycle pulse), len(5, stored byte count), trunc(1, MAXLEN reached without terminator), err(1, responder absent or bad byte).
REQ-013 SHALL have port buf_idx  input  4  and port buf_data  output  8  combinational read of stored byte buf_idx.

Function
REQ-014 SHALL implement states IDLE, SELECT, READ, GAP, DONE.
REQ-015 IDLE: start=1 -> SELECT next cycle; start while busy SHALL be ignored.
REQ-016 SELECT (1 cycle): zxuno_addr=REG_ADDR, regaddr_changed=1, len/trunc/err cleared; -> READ.
REQ-017 READ: zxuno_regrd=1 for exactly RD_HOLD cycles; din and oe_n captured on the last READ cycle; -> GAP.
REQ-018 GAP: zxuno_regrd=0 for exactly 2 cycles, so responder advances its index and re-registers data.
REQ-019 Captured byte 0x00 SHALL be a terminator: not stored, len unchanged, run ends after GAP.
REQ-020 Captured non-zero byte SHALL be stored at buf[len], len incremented; if len reaches MAXLEN, trunc=1 and run ends after GAP.
REQ-021 oe_n=1 at capture SHALL set err=1, store nothing, end run after GAP.
REQ-022 Run end: DONE for 1 cycle with done=1, then IDLE; len/trunc/err held until next SELECT.
REQ-023 busy SHALL be 1 in SELECT, READ, GAP, DONE; 0 in IDLE.
REQ-024 zxuno_addr SHALL equal REG_ADDR while busy, 8'h00 in IDLE; regrd and regaddr_changed 0 outside READ/SELECT.
REQ-025 Per-byte period SHALL be RD_HOLD+2 cycles; len SHALL never exceed MAXLEN.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, busy=0, done=0, len=0, trunc=0, err=0, zxuno_regrd=0, regaddr_changed=0, zxuno_addr=8'h00, including mid-run.
REQ-027 Buffer contents SHALL NOT be reset; after reset, buf_data content is undefined until a run stores it.

Configuration
REQ-028 With COREID_READER_ASCII_CHECK_EN defined, a captured non-zero byte outside 0x20..0x7E SHALL set err=1, not be stored, and end the run after GAP.
REQ-029 Without COREID_READER_ASCII_CHECK_EN, every non-zero byte SHALL be stored without checking.

Structure
REQ-030 Package coreid_pkg SHALL hold REG_ADDR default 8'hFF, MAXLEN default 16, and the state encoding; shared with the coreid responder.
REQ-031 Byte storage SHALL be sub-module coreid_buf (16x8, one synchronous write port, one combinational read port); FSM and counters remain in coreid_reader.

Verification
REQ-032 Responder holding "T24-11022017"+0x00, RD_HOLD=3, start sampled at edge 0 -> regaddr_changed high at cycle 1, done high at cycle 67, len=12, buf[0]=0x54, buf[11]=0x37, trunc=0, err=0.
REQ-033 Responder returning 16 non-zero bytes 0x41..0x50 -> len=16, trunc=1, buf[15]=0x50, done after 16 byte periods.
REQ-034 oe_n tied high -> err=1, len=0, done at cycle 7 (1 SELECT + 5 + DONE).
REQ-035 rst pulsed in cycle 20 of a run -> all outputs reset values next edge; new start then re-fetches with len=12.
REQ-036 start held high throughout a run -> exactly one run; second run begins only after return to IDLE.
REQ-037 Byte 0x07 at position 2 -> with COREID_READER_ASCII_CHECK_EN: err=1, len=2; without it: stored, len=12.
